// File: rtl/uart_frame_tx_if.sv
// uart_frame_tx_if
// Groups the frame-request handshake and the serial output of uart_frame_tx.
//   start   : single-cycle frame request (master -> slave)
//   data_in : 8*DATA_BYTES payload, most-significant byte sent first
//   busy    : high while a frame is in progress (slave -> master)
//   done    : one-cycle pulse after the final stop bit (slave -> master)
//   tx      : serial line, idle high (slave -> master)
interface uart_frame_tx_if #(
  parameter int DATA_BYTES = 16
);
  logic                    start;
  logic [8*DATA_BYTES-1:0] data_in;
  logic                    busy;
  logic                    done;
  logic                    tx;

  modport master (output start, data_in, input busy, done, tx);
  modport slave  (input start, data_in, output busy, done, tx);
endinterface

// File: rtl/uart_frame_tx.sv
// uart_frame_tx
// Serialises one frame per start strobe: HEADER, then DATA_BYTES payload
// bytes (most-significant byte first), each sent 8N1 and LSB first.
// Bytes follow each other with no idle time; done pulses for one cycle
// when the last stop bit ends, together with busy falling.
//
// Ports:
//   clk_100m : system clock
//   NRST     : asynchronous active-low reset
//   bus      : uart_frame_tx_if slave (start, data_in, busy, done, tx)
//
// Optional feature macro: UART_TX_CHKSUM_EN
//   When defined, a checksum byte (XOR of all payload bytes, header not
//   included) is sent after the last payload byte.
module uart_frame_tx #(
  parameter int          BIT_PERIOD = 10416,
  parameter logic [7:0]  HEADER     = 8'h01,
  parameter int          DATA_BYTES = 16
) (
  input  logic           clk_100m,
  input  logic           NRST,
  uart_frame_tx_if.slave bus
);

  localparam int BYTE_W = $clog2(DATA_BYTES + 2);
`ifdef UART_TX_CHKSUM_EN
  localparam int LAST_BYTE = DATA_BYTES + 1;
`else
  localparam int LAST_BYTE = DATA_BYTES;
`endif
  localparam logic [BYTE_W-1:0] LAST_IDX  = BYTE_W'(LAST_BYTE);
  localparam logic [15:0]       BAUD_LAST = 16'(BIT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e                  state_q, state_d;
  logic [15:0]             baudCnt_q, baudCnt_d;
  logic [2:0]              bitCnt_q, bitCnt_d;
  logic [BYTE_W-1:0]       byteCnt_q, byteCnt_d;
  logic [7:0]              shift_q, shift_d;
  logic [8*DATA_BYTES-1:0] payload_q, payload_d;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    bitEnd;
  logic [7:0]              nextByte;
`ifdef UART_TX_CHKSUM_EN
  localparam logic [BYTE_W-1:0] CHK_IDX = BYTE_W'(DATA_BYTES);
  logic [7:0]              chk_q, chk_d;
`endif

  assign bitEnd   = (baudCnt_q == BAUD_LAST);
  // The payload register is shifted up one byte per loaded byte, so the
  // next byte to send always sits in the top lane.
  assign nextByte = payload_q[8*DATA_BYTES-1 -: 8];

  // State and datapath registers; every output is registered here too.
  always_ff @(posedge clk_100m or negedge NRST) begin
    if (!NRST) begin
      state_q   <= IDLE;
      baudCnt_q <= '0;
      bitCnt_q  <= '0;
      byteCnt_q <= '0;
      shift_q   <= '0;
      payload_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_CHKSUM_EN
      chk_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      baudCnt_q <= baudCnt_d;
      bitCnt_q  <= bitCnt_d;
      byteCnt_q <= byteCnt_d;
      shift_q   <= shift_d;
      payload_q <= payload_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef UART_TX_CHKSUM_EN
      chk_q     <= chk_d;
`endif
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    baudCnt_d = baudCnt_q;
    bitCnt_d  = bitCnt_q;
    byteCnt_d = byteCnt_q;
    shift_d   = shift_q;
    payload_d = payload_q;
`ifdef UART_TX_CHKSUM_EN
    chk_d     = chk_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = START;
          shift_d   = HEADER;
          payload_d = bus.data_in;
          byteCnt_d = '0;
          baudCnt_d = '0;
          bitCnt_d  = '0;
`ifdef UART_TX_CHKSUM_EN
          chk_d     = '0;
`endif
        end
      end
      START: begin
        if (bitEnd) begin
          baudCnt_d = '0;
          bitCnt_d  = '0;
          state_d   = DATA;
        end else begin
          baudCnt_d = baudCnt_q + 16'd1;
        end
      end
      DATA: begin
        if (bitEnd) begin
          baudCnt_d = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          if (bitCnt_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bitCnt_d = bitCnt_q + 3'd1;
          end
        end else begin
          baudCnt_d = baudCnt_q + 16'd1;
        end
      end
      STOP: begin
        if (bitEnd) begin
          baudCnt_d = '0;
          if (byteCnt_q == LAST_IDX) begin
            state_d   = IDLE;
            byteCnt_d = '0;
          end else begin
            // Next byte goes straight to its start bit: no idle gap.
            state_d   = START;
            byteCnt_d = byteCnt_q + BYTE_W'(1);
`ifdef UART_TX_CHKSUM_EN
            if (byteCnt_q == CHK_IDX) begin
              shift_d = chk_q;
            end else begin
              shift_d   = nextByte;
              payload_d = payload_q << 8;
              chk_d     = chk_q ^ nextByte;
            end
`else
            shift_d   = nextByte;
            payload_d = payload_q << 8;
`endif
          end
        end else begin
          baudCnt_d = baudCnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state, so the registered outputs change on
  // the same edge as the state (tx falls on the edge that accepts start).
  always_comb begin
    busy_d = (state_d != IDLE);
    done_d = (state_q == STOP) && (state_d == IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// tb_uart_frame_tx
// Self-checking bench for uart_frame_tx with BIT_PERIOD=16, DATA_BYTES=16.
// A frame-level model predicts tx/busy/done every cycle from the list of
// bytes a frame must carry; an independent line decoder recovers bytes
// from tx for literal checks. Honours UART_TX_CHKSUM_EN like the design.
`timescale 1ns/1ps
module tb_uart_frame_tx;

  localparam int         BP  = 16;
  localparam int         NB  = 16;
  localparam logic [7:0] HDR = 8'h01;
`ifdef UART_TX_CHKSUM_EN
  localparam int NFRAME = NB + 2;
`else
  localparam int NFRAME = NB + 1;
`endif

  typedef logic [7:0] byteq_t[$];

  logic clk_100m = 1'b0;
  logic NRST     = 1'b0;
  int   cyc      = 0;

  uart_frame_tx_if #(.DATA_BYTES(NB)) bus ();

  uart_frame_tx #(
    .BIT_PERIOD(BP),
    .HEADER    (HDR),
    .DATA_BYTES(NB)
  ) dut (
    .clk_100m(clk_100m),
    .NRST    (NRST),
    .bus     (bus)
  );

  always #5 clk_100m = ~clk_100m;
  always @(posedge clk_100m) cyc++;

  int errors = 0;
  int checks = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bytes a frame must carry, straight from the frame definition.
  function automatic byteq_t frameOf(input logic [8*NB-1:0] d);
    byteq_t     q;
    logic [7:0] b;
    logic [7:0] x;
    x = 8'h00;
    q.push_back(HDR);
    for (int k = 0; k < NB; k++) begin
      b = d[8*(NB-1-k) +: 8];
      q.push_back(b);
      x = x ^ b;
    end
`ifdef UART_TX_CHKSUM_EN
    q.push_back(x);
`endif
    return q;
  endfunction

  // Frame-level model: on acceptance it expands the frame into its line
  // bits (start, 8 data LSB first, stop); each bit lasts BP cycles and done
  // follows immediately after the last bit.
  bit     mBusy  = 1'b0;
  bit     mDone  = 1'b0;
  int     mCount = 0;
  int     mTotal = 0;
  bit     mBits[$];
  byteq_t mFrame;

  always @(posedge clk_100m or negedge NRST) begin
    if (!NRST) begin
      mBusy  = 1'b0;
      mDone  = 1'b0;
      mCount = 0;
    end else begin
      mDone = 1'b0;
      if (mBusy) begin
        mCount++;
        if (mCount == mTotal) begin
          mBusy = 1'b0;
          mDone = 1'b1;
        end
      end else if (bus.start) begin
        mFrame = frameOf(bus.data_in);
        mBits.delete();
        foreach (mFrame[i]) begin
          mBits.push_back(1'b0);
          for (int j = 0; j < 8; j++) mBits.push_back(mFrame[i][j]);
          mBits.push_back(1'b1);
        end
        mTotal = mBits.size() * BP;
        mCount = 0;
        mBusy  = 1'b1;
      end
    end
  end

  // Cycle-by-cycle comparison of the DUT outputs against the model.
  logic eTx;
  always @(negedge clk_100m) begin
    if (NRST) begin
      eTx = mBusy ? mBits[mCount / BP] : 1'b1;
      checkOutput("tx/busy/done", {29'b0, bus.tx, bus.busy, bus.done},
                  {29'b0, eTx, mBusy, mDone});
    end
  end

  // Line decoder: samples mid-bit relative to the detected start edge.
  bit         dActive = 1'b0;
  int         dCnt    = 0;
  int         dK      = 0;
  logic [7:0] dByte   = 8'h00;
  byteq_t     rx;
  int         doneCnt = 0;

  always @(negedge clk_100m) begin
    if (!NRST) begin
      dActive = 1'b0;
    end else if (!dActive) begin
      if (bus.tx == 1'b0) begin
        dActive = 1'b1;
        dCnt    = 0;
      end
    end else begin
      dCnt++;
      if (dCnt % BP == BP / 2) begin
        dK = dCnt / BP;
        if (dK == 0) begin
          checkOutput("start bit", {31'b0, bus.tx}, 32'd0);
        end else if (dK <= 8) begin
          dByte = {bus.tx, dByte[7:1]};
        end else begin
          checkOutput("stop bit", {31'b0, bus.tx}, 32'd1);
          rx.push_back(dByte);
          dActive = 1'b0;
        end
      end
    end
  end

  always @(negedge clk_100m) if (NRST && bus.done) doneCnt++;

  task automatic applyStimulus(input logic [8*NB-1:0] d);
    @(negedge clk_100m);
    bus.data_in = d;
    bus.start   = 1'b1;
    @(negedge clk_100m);
    bus.start   = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < budget) begin
      @(negedge clk_100m);
      n++;
    end
    checkOutput("done seen", {31'b0, bus.done}, 32'd1);
  endtask

  logic [7:0]      lit2 [17] = '{8'h01, 8'h69, 8'hc4, 8'he0, 8'hd8, 8'h6a, 8'h7b, 8'h04, 8'h30,
                                 8'hd8, 8'hcd, 8'hb7, 8'h80, 8'h70, 8'hb4, 8'hc5, 8'h5a};
  logic [8*NB-1:0] data2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  logic [8*NB-1:0] rnd;
  byteq_t          exp;
  int              t0;
  int              frameLen;

  initial begin
    bus.start   = 1'b0;
    bus.data_in = '0;
    frameLen    = 10 * NFRAME * BP;

    // Reset held for 5 cycles, then idle without start.
    NRST = 1'b0;
    repeat (5) begin
      @(negedge clk_100m);
      checkOutput("reset outputs", {29'b0, bus.tx, bus.busy, bus.done}, 32'b100);
    end
    NRST = 1'b1;
    repeat (20) @(negedge clk_100m);
    checkOutput("idle tx", {31'b0, bus.tx}, 32'd1);

    // Single frame with the reference payload.
    rx.delete(); doneCnt = 0;
    applyStimulus(data2);
    t0 = cyc;
    checkOutput("tx low after start", {31'b0, bus.tx}, 32'd0);
    waitDone(4000);
    checkOutput("done delay", cyc - t0, 32'(frameLen));
    checkOutput("busy low at done", {31'b0, bus.busy}, 32'd0);
    repeat (5) @(negedge clk_100m);
    checkOutput("frame2 size", rx.size(), 32'(NFRAME));
    for (int i = 0; i < 17; i++) checkOutput("frame2 byte", rx[i], lit2[i]);
    checkOutput("frame2 done count", doneCnt, 32'd1);

    // Start while busy is ignored; data_in changes after acceptance.
    rx.delete(); doneCnt = 0;
    applyStimulus(data2);
    repeat (498) @(negedge clk_100m);
    bus.data_in = '1;
    bus.start   = 1'b1;
    @(negedge clk_100m);
    bus.start   = 1'b0;
    bus.data_in = {$urandom, $urandom, $urandom, $urandom};
    waitDone(4000);
    repeat (5) @(negedge clk_100m);
    checkOutput("frame3 size", rx.size(), 32'(NFRAME));
    for (int i = 0; i < 17; i++) checkOutput("frame3 byte", rx[i], lit2[i]);
    checkOutput("frame3 done count", doneCnt, 32'd1);

    // Reset mid-frame acts asynchronously; a new frame starts cleanly.
    applyStimulus(data2);
    repeat (999) @(negedge clk_100m);
    #2 NRST = 1'b0;
    #1;
    checkOutput("async reset tx", {31'b0, bus.tx}, 32'd1);
    checkOutput("async reset busy", {31'b0, bus.busy}, 32'd0);
    repeat (3) @(negedge clk_100m);
    NRST = 1'b1;
    rx.delete(); doneCnt = 0;
    rnd = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(rnd);
    waitDone(4000);
    repeat (2) @(negedge clk_100m);
    exp = frameOf(rnd);
    checkOutput("post-reset size", rx.size(), 32'(NFRAME));
    checkOutput("post-reset header", rx[0], 32'h01);
    for (int i = 0; i < NFRAME; i++) checkOutput("post-reset byte", rx[i], exp[i]);

    // Back-to-back: start in the done cycle.
    rx.delete(); doneCnt = 0;
    applyStimulus(data2);
    waitDone(4000);
    rnd = {$urandom, $urandom, $urandom, $urandom};
    bus.data_in = rnd;
    bus.start   = 1'b1;
    @(negedge clk_100m);
    bus.start   = 1'b0;
    checkOutput("b2b tx low", {31'b0, bus.tx}, 32'd0);
    waitDone(4000);
    repeat (2) @(negedge clk_100m);
    checkOutput("b2b size", rx.size(), 32'(2 * NFRAME));
    checkOutput("b2b second header", rx[NFRAME], 32'h01);
    checkOutput("b2b first payload", rx[1], 32'h69);
    checkOutput("b2b done count", doneCnt, 32'd2);

    // Only the last payload byte non-zero.
    rx.delete(); doneCnt = 0;
    applyStimulus(128'hA5);
    t0 = cyc;
    waitDone(4000);
`ifdef UART_TX_CHKSUM_EN
    checkOutput("a5 done delay", cyc - t0, 32'd2880);
`else
    checkOutput("a5 done delay", cyc - t0, 32'd2720);
`endif
    repeat (2) @(negedge clk_100m);
    checkOutput("a5 size", rx.size(), 32'(NFRAME));
    checkOutput("a5 last byte", rx[rx.size()-1], 32'hA5);
    checkOutput("a5 payload end", rx[NB], 32'hA5);

    // Random payloads with random idle gaps.
    for (int f = 0; f < 4; f++) begin
      rx.delete();
      repeat ($urandom_range(0, 20)) @(negedge clk_100m);
      rnd = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(rnd);
      waitDone(4000);
      repeat (2) @(negedge clk_100m);
      exp = frameOf(rnd);
      checkOutput("random size", rx.size(), 32'(NFRAME));
      for (int i = 0; i < NFRAME; i++) checkOutput("random byte", rx[i], exp[i]);
    end

    repeat (10) @(negedge clk_100m);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
